// File: rtl/psrv_pkg.sv
// Shared definitions for the pipeline: datapath widths, ALU opcodes, operand selects
// and a register-match helper used by the hazard logic.
package psrv_pkg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 6;
    localparam int RA_W    = 5;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 6'd0,
        ALU_SLL  = 6'd1,
        ALU_SLT  = 6'd2,
        ALU_SLTU = 6'd3,
        ALU_XOR  = 6'd4,
        ALU_SRL  = 6'd5,
        ALU_OR   = 6'd6,
        ALU_AND  = 6'd7,
        ALU_SRA  = 6'd8,
        ALU_SUB  = 6'd9
    } alu_op_e;

    localparam logic OP1_RS1 = 1'b0;
    localparam logic OP1_PC  = 1'b1;
    localparam logic OP2_RS2 = 1'b0;
    localparam logic OP2_IMM = 1'b1;

    // A writer hits a source only when it writes a real register (x0 never matches).
    function automatic logic reg_hit(input logic we, input logic [RA_W-1:0] rd,
                                     input logic [RA_W-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_hazard_unit.sv
// Combinational operand forwarding and load-use / RAW stall detection.
// PSRV_FWD_EN enables the EX/MEM/WB bypass paths; without it every RAW hazard stalls.
module id_ex_hazard_unit #(
    parameter int XLEN = psrv_pkg::XLEN,
    parameter int RA_W = psrv_pkg::RA_W
) (
    input  logic [RA_W-1:0] rs1_addr_i,
    input  logic [RA_W-1:0] rs2_addr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            op1_sel_i,
    input  logic            ex_valid_i,
    input  logic            ex_rd_we_i,
    input  logic [RA_W-1:0] ex_rd_addr_i,
    input  logic            ex_is_load_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic            mem_we_i,
    input  logic [RA_W-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            wb_we_i,
    input  logic [RA_W-1:0] wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] fwd_rs1_o,
    output logic [XLEN-1:0] fwd_rs2_o,
    output logic            load_use_o
);
    import psrv_pkg::*;

    logic rs1_read;
    assign rs1_read = (op1_sel_i == OP1_RS1);

`ifdef PSRV_FWD_EN
    logic ex_alu_wr;
    logic ex_load_wr;

    assign ex_alu_wr  = ex_valid_i & ex_rd_we_i & ~ex_is_load_i;
    assign ex_load_wr = ex_valid_i & ex_rd_we_i & ex_is_load_i;

    always_comb begin
        fwd_rs1_o = rs1_data_i;
        if (rs1_addr_i == '0)                                  fwd_rs1_o = '0;
        else if (reg_hit(ex_alu_wr, ex_rd_addr_i, rs1_addr_i)) fwd_rs1_o = ex_result_i;
        else if (reg_hit(mem_we_i, mem_addr_i, rs1_addr_i))    fwd_rs1_o = mem_data_i;
        else if (reg_hit(wb_we_i, wb_addr_i, rs1_addr_i))      fwd_rs1_o = wb_data_i;

        fwd_rs2_o = rs2_data_i;
        if (rs2_addr_i == '0)                                  fwd_rs2_o = '0;
        else if (reg_hit(ex_alu_wr, ex_rd_addr_i, rs2_addr_i)) fwd_rs2_o = ex_result_i;
        else if (reg_hit(mem_we_i, mem_addr_i, rs2_addr_i))    fwd_rs2_o = mem_data_i;
        else if (reg_hit(wb_we_i, wb_addr_i, rs2_addr_i))      fwd_rs2_o = wb_data_i;
    end

    // rs2 always counts: even with an immediate operand it still feeds store data.
    assign load_use_o = (rs1_read & reg_hit(ex_load_wr, ex_rd_addr_i, rs1_addr_i))
                      | reg_hit(ex_load_wr, ex_rd_addr_i, rs2_addr_i);
`else
    logic ex_wr;
    logic rs1_hit;
    logic rs2_hit;
    logic unused_bypass;

    assign ex_wr = ex_valid_i & ex_rd_we_i;

    assign fwd_rs1_o = (rs1_addr_i == '0) ? '0 : rs1_data_i;
    assign fwd_rs2_o = (rs2_addr_i == '0) ? '0 : rs2_data_i;

    // Any in-flight writer of a read source stalls until it has retired through WB.
    assign rs1_hit = reg_hit(ex_wr, ex_rd_addr_i, rs1_addr_i)
                   | reg_hit(mem_we_i, mem_addr_i, rs1_addr_i)
                   | reg_hit(wb_we_i, wb_addr_i, rs1_addr_i);
    assign rs2_hit = reg_hit(ex_wr, ex_rd_addr_i, rs2_addr_i)
                   | reg_hit(mem_we_i, mem_addr_i, rs2_addr_i)
                   | reg_hit(wb_we_i, wb_addr_i, rs2_addr_i);

    assign load_use_o = (rs1_read & rs1_hit) | rs2_hit;

    assign unused_bypass = ^{ex_result_i, mem_data_i, wb_data_i, ex_is_load_i};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand selection and hazard handling in front of the ALU.
// Bypassing is built only when PSRV_FWD_EN is defined; otherwise RAW hazards stall.
module id_ex_stage #(
    parameter int XLEN    = psrv_pkg::XLEN,
    parameter int ALUOP_W = psrv_pkg::ALUOP_W,
    parameter int RA_W    = psrv_pkg::RA_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               id_valid_i,
    output logic               id_ready_o,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [XLEN-1:0]    imm_i,
    input  logic [RA_W-1:0]    rs1_addr_i,
    input  logic [RA_W-1:0]    rs2_addr_i,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [XLEN-1:0]    rs2_data_i,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic               op1_sel_i,
    input  logic               op2_sel_i,
    input  logic [RA_W-1:0]    rd_addr_i,
    input  logic               rd_we_i,
    input  logic               is_load_i,
    input  logic [XLEN-1:0]    ex_result_i,
    input  logic               mem_we_i,
    input  logic [RA_W-1:0]    mem_addr_i,
    input  logic [XLEN-1:0]    mem_data_i,
    input  logic               wb_we_i,
    input  logic [RA_W-1:0]    wb_addr_i,
    input  logic [XLEN-1:0]    wb_data_i,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output logic [XLEN-1:0]    op1_o,
    output logic [XLEN-1:0]    op2_o,
    output logic [ALUOP_W-1:0] aluop_o,
    output logic [XLEN-1:0]    store_data_o,
    output logic [XLEN-1:0]    pc_o,
    output logic [RA_W-1:0]    rd_addr_o,
    output logic               rd_we_o,
    output logic               is_load_o
);
    import psrv_pkg::*;

    logic               ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]    op1_q, op1_d;
    logic [XLEN-1:0]    op2_q, op2_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic [XLEN-1:0]    store_data_q, store_data_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [RA_W-1:0]    rd_addr_q, rd_addr_d;
    logic               rd_we_q, rd_we_d;
    logic               is_load_q, is_load_d;

    logic [XLEN-1:0]    fwd_rs1;
    logic [XLEN-1:0]    fwd_rs2;
    logic               load_use;
    logic               advance;
    logic               accept;

    id_ex_hazard_unit #(
        .XLEN (XLEN),
        .RA_W (RA_W)
    ) u_hazard (
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .op1_sel_i    (op1_sel_i),
        .ex_valid_i   (ex_valid_q),
        .ex_rd_we_i   (rd_we_q),
        .ex_rd_addr_i (rd_addr_q),
        .ex_is_load_i (is_load_q),
        .ex_result_i  (ex_result_i),
        .mem_we_i     (mem_we_i),
        .mem_addr_i   (mem_addr_i),
        .mem_data_i   (mem_data_i),
        .wb_we_i      (wb_we_i),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i),
        .fwd_rs1_o    (fwd_rs1),
        .fwd_rs2_o    (fwd_rs2),
        .load_use_o   (load_use)
    );

    assign advance    = ~ex_valid_q | ex_ready_i;
    assign accept     = advance & ~load_use & ~flush_i & id_valid_i;
    assign id_ready_o = flush_i | (advance & ~load_use);

    // Payload only moves on accept, so a stalled EX sees perfectly stable operands.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        aluop_d      = aluop_q;
        store_data_d = store_data_q;
        pc_d         = pc_q;
        rd_addr_d    = rd_addr_q;
        rd_we_d      = rd_we_q;
        is_load_d    = is_load_q;

        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (advance) begin
            ex_valid_d = id_valid_i & ~load_use;
        end

        if (accept) begin
            op1_d        = (op1_sel_i == OP1_PC)  ? pc_i  : fwd_rs1;
            op2_d        = (op2_sel_i == OP2_IMM) ? imm_i : fwd_rs2;
            aluop_d      = aluop_i;
            store_data_d = fwd_rs2;
            pc_d         = pc_i;
            rd_addr_d    = rd_addr_i;
            rd_we_d      = rd_we_i;
            is_load_d    = is_load_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q   <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            aluop_q      <= '0;
            store_data_q <= '0;
            pc_q         <= '0;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
            is_load_q    <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            aluop_q      <= aluop_d;
            store_data_q <= store_data_d;
            pc_q         <= pc_d;
            rd_addr_q    <= rd_addr_d;
            rd_we_q      <= rd_we_d;
            is_load_q    <= is_load_d;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign op1_o        = op1_q;
    assign op2_o        = op2_q;
    assign aluop_o      = aluop_q;
    assign store_data_o = store_data_q;
    assign pc_o         = pc_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_we_o      = rd_we_q;
    assign is_load_o    = is_load_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations adapt to whether PSRV_FWD_EN is defined.
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [5:0]  aluop;
        logic [31:0] sd;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [31:0] pc = '0, imm = '0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic [31:0] rs1_data = '0, rs2_data = '0;
    logic [5:0]  aluop = '0;
    logic        op1_sel = 1'b0, op2_sel = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic        rd_we = 1'b0, is_load = 1'b0;
    logic [31:0] ex_result = '0;
    logic        mem_we = 1'b0;
    logic [4:0]  mem_addr = '0;
    logic [31:0] mem_data = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ex_valid;
    logic        ex_ready = 1'b1;
    logic [31:0] op1, op2, store_data, pc_out;
    logic [5:0]  aluop_out;
    logic [4:0]  rd_out;
    logic        rd_we_out, is_load_out;

    exp_t sb[$];
    logic exp_valid = 1'b0, exp_ready = 1'b1, chk = 1'b0, done = 1'b0;
    int   total = 0, bad = 0;

    id_ex_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .id_valid_i   (id_valid),
        .id_ready_o   (id_ready),
        .pc_i         (pc),
        .imm_i        (imm),
        .rs1_addr_i   (rs1_addr),
        .rs2_addr_i   (rs2_addr),
        .rs1_data_i   (rs1_data),
        .rs2_data_i   (rs2_data),
        .aluop_i      (aluop),
        .op1_sel_i    (op1_sel),
        .op2_sel_i    (op2_sel),
        .rd_addr_i    (rd_addr),
        .rd_we_i      (rd_we),
        .is_load_i    (is_load),
        .ex_result_i  (ex_result),
        .mem_we_i     (mem_we),
        .mem_addr_i   (mem_addr),
        .mem_data_i   (mem_data),
        .wb_we_i      (wb_we),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data),
        .ex_valid_o   (ex_valid),
        .ex_ready_i   (ex_ready),
        .op1_o        (op1),
        .op2_o        (op2),
        .aluop_o      (aluop_out),
        .store_data_o (store_data),
        .pc_o         (pc_out),
        .rd_addr_o    (rd_out),
        .rd_we_o      (rd_we_out),
        .is_load_o    (is_load_out)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] o1, input logic [31:0] o2, input logic [5:0] op,
                                input logic [31:0] sd, input logic [31:0] p, input logic [4:0] rd,
                                input logic we, input logic ld);
        exp_t e;
        e.op1 = o1; e.op2 = o2; e.aluop = op; e.sd = sd; e.pc = p; e.rd = rd; e.we = we; e.ld = ld;
        return e;
    endfunction

    task automatic step(input logic v, input logic r);
        exp_valid = v;
        exp_ready = r;
        chk = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] p, input logic [31:0] im, input logic [4:0] a1,
                         input logic [31:0] d1, input logic [4:0] a2, input logic [31:0] d2,
                         input logic [5:0] op, input logic s1, input logic s2,
                         input logic [4:0] rd, input logic ld);
        id_valid = 1'b1; pc = p; imm = im;
        rs1_addr = a1; rs1_data = d1; rs2_addr = a2; rs2_data = d2;
        aluop = op; op1_sel = s1; op2_sel = s2; rd_addr = rd; rd_we = 1'b1; is_load = ld;
    endtask

    task automatic idle();
        id_valid = 1'b0; mem_we = 1'b0; wb_we = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: per-cycle handshake checks, stall stability, and scoreboard pops on transfer.
    initial begin
        exp_t act, e, snap;
        logic held;
        held = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (chk) begin
                act = {op1, op2, aluop_out, store_data, pc_out, rd_out, rd_we_out, is_load_out};
                cmp("ex_valid", {31'b0, ex_valid}, {31'b0, exp_valid});
                cmp("id_ready", {31'b0, id_ready}, {31'b0, exp_ready});
                if (rst) begin
                    total++;
                    if (act !== '0) begin
                        bad++;
                        $display("FAIL reset_regs: got %h want 0", act);
                    end
                end
                if (held && ex_valid) begin
                    total++;
                    if (act !== snap) begin
                        bad++;
                        $display("FAIL stall_stable: got %h want %h", act, snap);
                    end
                end
                held = ex_valid && !ex_ready && !rst;
                snap = act;
                if (ex_valid && ex_ready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL xfer: unexpected transfer pc=%h, want none", pc_out);
                    end else begin
                        e = sb.pop_front();
                        if (act !== e) begin
                            bad++;
                            $display("FAIL xfer: got op1=%h op2=%h aluop=%h sd=%h pc=%h rd=%h we=%b ld=%b want op1=%h op2=%h aluop=%h sd=%h pc=%h rd=%h we=%b ld=%b",
                                     act.op1, act.op2, act.aluop, act.sd, act.pc, act.rd, act.we, act.ld,
                                     e.op1, e.op2, e.aluop, e.sd, e.pc, e.rd, e.we, e.ld);
                        end
                    end
                end
                if (done) begin
                    cmp("sb_empty", sb.size(), 32'd0);
                    $display("test done: total=%0d bad=%0d", total, bad);
                    $finish;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        // reset
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        rst = 1'b0;

        // ADD x7, x1(=5), imm 7
        issue(32'h100, 32'd7, 5'd1, 32'd5, 5'd2, 32'd99, 6'd0, 1'b0, 1'b1, 5'd7, 1'b0);
        sb.push_back(mk(32'd5, 32'd7, 6'd0, 32'd99, 32'h100, 5'd7, 1'b1, 1'b0));
        step(1'b0, 1'b1);
        idle();
        step(1'b1, 1'b1);

        // addi x3, x0, 0x10 then sub x4, x3, x2
        issue(32'h104, 32'h10, 5'd0, 32'd0, 5'd0, 32'd0, 6'd0, 1'b0, 1'b1, 5'd3, 1'b0);
        sb.push_back(mk(32'h0, 32'h10, 6'd0, 32'h0, 32'h104, 5'd3, 1'b1, 1'b0));
        step(1'b0, 1'b1);
        issue(32'h108, 32'h0, 5'd3, 32'd0, 5'd2, 32'd4, 6'd9, 1'b0, 1'b0, 5'd4, 1'b0);
        ex_result = 32'h10;
        mem_we = 1'b1; mem_addr = 5'd3; mem_data = 32'h99;
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h99;
`ifdef PSRV_FWD_EN
        sb.push_back(mk(32'h10, 32'd4, 6'd9, 32'd4, 32'h108, 5'd4, 1'b1, 1'b0));
        step(1'b1, 1'b1);
`else
        step(1'b1, 1'b0);
        mem_data = 32'h10; wb_we = 1'b0;
        step(1'b0, 1'b0);
        mem_we = 1'b0; wb_we = 1'b1; wb_data = 32'h10;
        step(1'b0, 1'b0);
        wb_we = 1'b0; rs1_data = 32'h10;
        sb.push_back(mk(32'h10, 32'd4, 6'd9, 32'd4, 32'h108, 5'd4, 1'b1, 1'b0));
        step(1'b0, 1'b1);
`endif
        idle();
        step(1'b1, 1'b1);

        // slt x8, x5 (WB), imm 3; x6 from MEM feeds store data
        issue(32'h120, 32'd3, 5'd5, 32'h11, 5'd6, 32'h22, 6'd2, 1'b0, 1'b1, 5'd8, 1'b0);
        mem_we = 1'b1; mem_addr = 5'd6; mem_data = 32'h66;
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
`ifndef PSRV_FWD_EN
        step(1'b0, 1'b0);
        mem_we = 1'b0; wb_we = 1'b0; rs1_data = 32'h55; rs2_data = 32'h66;
`endif
        sb.push_back(mk(32'h55, 32'd3, 6'd2, 32'h66, 32'h120, 5'd8, 1'b1, 1'b0));
        step(1'b0, 1'b1);
        idle();
        step(1'b1, 1'b1);

        // lw x5 then add x6, x5, x0: one bubble, then load data from MEM
        issue(32'h10C, 32'd4, 5'd1, 32'h200, 5'd0, 32'd0, 6'd0, 1'b0, 1'b1, 5'd5, 1'b1);
        sb.push_back(mk(32'h200, 32'd4, 6'd0, 32'd0, 32'h10C, 5'd5, 1'b1, 1'b1));
        step(1'b0, 1'b1);
        issue(32'h110, 32'd0, 5'd5, 32'd0, 5'd0, 32'd0, 6'd0, 1'b0, 1'b0, 5'd6, 1'b0);
        ex_result = 32'h204;
        step(1'b1, 1'b0);
        mem_we = 1'b1; mem_addr = 5'd5; mem_data = 32'hABCD;
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1111;
`ifndef PSRV_FWD_EN
        step(1'b0, 1'b0);
        mem_we = 1'b0; wb_data = 32'hABCD;
        step(1'b0, 1'b0);
        wb_we = 1'b0; rs1_data = 32'hABCD;
`endif
        sb.push_back(mk(32'hABCD, 32'd0, 6'd0, 32'd0, 32'h110, 5'd6, 1'b1, 1'b0));
        step(1'b0, 1'b1);
        idle();
        step(1'b1, 1'b1);

        // downstream stall for 3 cycles with a pending ID instruction
        issue(32'h200, 32'h33, 5'd1, 32'd1, 5'd2, 32'h44, 6'd6, 1'b1, 1'b1, 5'd9, 1'b0);
        sb.push_back(mk(32'h200, 32'h33, 6'd6, 32'h44, 32'h200, 5'd9, 1'b1, 1'b0));
        step(1'b0, 1'b1);
        issue(32'h204, 32'h0, 5'd10, 32'hA, 5'd11, 32'hB, 6'd4, 1'b0, 1'b0, 5'd12, 1'b0);
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        ex_ready = 1'b1;
        sb.push_back(mk(32'hA, 32'hB, 6'd4, 32'hB, 32'h204, 5'd12, 1'b1, 1'b0));
        step(1'b1, 1'b1);
        idle();
        step(1'b1, 1'b1);

        // flush during stall while ID also presents an instruction
        issue(32'h220, 32'h1, 5'd0, 32'd0, 5'd0, 32'd0, 6'd7, 1'b0, 1'b1, 5'd13, 1'b0);
        step(1'b0, 1'b1);
        issue(32'h224, 32'h2, 5'd0, 32'd0, 5'd0, 32'd0, 6'd8, 1'b0, 1'b1, 5'd14, 1'b0);
        ex_ready = 1'b0; flush = 1'b1;
        step(1'b1, 1'b1);
        idle();
        step(1'b0, 1'b1);

        // EX writes x0 with 0xFFFF; ID reads x0 without a bubble
        issue(32'h300, 32'd5, 5'd0, 32'd0, 5'd0, 32'd0, 6'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        sb.push_back(mk(32'd0, 32'd5, 6'd0, 32'd0, 32'h300, 5'd0, 1'b1, 1'b0));
        step(1'b0, 1'b1);
        issue(32'h304, 32'd0, 5'd0, 32'h1234, 5'd0, 32'h5678, 6'd0, 1'b0, 1'b0, 5'd14, 1'b0);
        ex_result = 32'hFFFF;
        sb.push_back(mk(32'd0, 32'd0, 6'd0, 32'd0, 32'h304, 5'd14, 1'b1, 1'b0));
        step(1'b1, 1'b1);
        idle();
        step(1'b1, 1'b1);

        // load in EX, but rs1 unused because op1 selects PC: no bubble
        issue(32'h400, 32'd8, 5'd0, 32'd0, 5'd0, 32'd0, 6'd0, 1'b0, 1'b1, 5'd7, 1'b1);
        sb.push_back(mk(32'd0, 32'd8, 6'd0, 32'd0, 32'h400, 5'd7, 1'b1, 1'b1));
        step(1'b0, 1'b1);
        issue(32'h404, 32'h1000, 5'd7, 32'h777, 5'd0, 32'd0, 6'd0, 1'b1, 1'b1, 5'd16, 1'b0);
        sb.push_back(mk(32'h404, 32'h1000, 6'd0, 32'd0, 32'h404, 5'd16, 1'b1, 1'b0));
        step(1'b1, 1'b1);
        idle();
        step(1'b1, 1'b1);

        // asynchronous reset in the middle of a downstream stall
        issue(32'h500, 32'd1, 5'd0, 32'd0, 5'd0, 32'd0, 6'd3, 1'b0, 1'b1, 5'd15, 1'b0);
        step(1'b0, 1'b1);
        id_valid = 1'b0; ex_ready = 1'b0;
        step(1'b1, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b1);
        rst = 1'b0; ex_ready = 1'b1;
        step(1'b0, 1'b1);

        done = 1'b1;
        step(1'b0, 1'b1);
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the EX-stage ALU. It captures a decoded instruction from ID and selects the ALU operands (rs1/PC, rs2/immediate), resolving RAW hazards by forwarding from EX, MEM and WB. It presents registered `op1_o`/`op2_o`/`aluop_o` to the ALU. A valid/ready handshake on both sides supports stall, flush and load-use bubble insertion.

## Interface
- `XLEN`, 32: datapath width.
- `ALUOP_W`, 6: ALU opcode width; matches ALU `aluop_i`.
- `RA_W`, 5: register address width.

- `clk_i` in 1: clock; all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: discard held and incoming instruction.
- `id_valid_i` in 1 / `id_ready_o` out 1: upstream handshake.
- `pc_i` in XLEN, `imm_i` in XLEN: instruction PC, decoded immediate.
- `rs1_addr_i`, `rs2_addr_i` in RA_W; `rs1_data_i`, `rs2_data_i` in XLEN: register-file read.
- `aluop_i` in ALUOP_W; `op1_sel_i` in 1 (0 = rs1, 1 = PC); `op2_sel_i` in 1 (0 = rs2, 1 = imm).
- `rd_addr_i` in RA_W, `rd_we_i` in 1, `is_load_i` in 1.
- `ex_result_i` in XLEN: ALU result for the instruction currently held here.
- `mem_we_i` in 1, `mem_addr_i` in RA_W, `mem_data_i` in XLEN: MEM-stage writeback. For loads, `mem_data_i` is the load data.
- `wb_we_i` in 1, `wb_addr_i` in RA_W, `wb_data_i` in XLEN: WB-stage writeback.
- `ex_valid_o` out 1 / `ex_ready_i` in 1: downstream handshake.
- `op1_o`, `op2_o` out XLEN; `aluop_o` out ALUOP_W: ALU operands.
- `store_data_o` out XLEN: forwarded rs2, independent of `op2_sel_i`.
- `pc_o` out XLEN, `rd_addr_o` out RA_W, `rd_we_o` out 1, `is_load_o` out 1.

## Operation
- Forwarded value for source `rsN`, in priority order:
  - `rsN == 0`: value is 0.
  - EX holds a non-load writer of `rsN` (`ex_valid_o & rd_we_o & rd_addr_o == rsN`): `ex_result_i`.
  - `mem_we_i & mem_addr_i == rsN`: `mem_data_i`.
  - `wb_we_i & wb_addr_i == rsN`: `wb_data_i`.
  - Otherwise: `rsN_data_i`.
- Operand select: `op1 = op1_sel_i ? pc_i : fwd_rs1`; `op2 = op2_sel_i ? imm_i : fwd_rs2`.
- `load_use` = `ex_valid_o & is_load_o & rd_we_o & rd_addr_o != 0 & rd_addr_o` equals a source that is actually read.
  - rs1 counts only when `op1_sel_i == 0`.
  - rs2 always counts, because store data needs it.
- `advance` = `!ex_valid_o | ex_ready_i`.
- `id_ready_o` = `flush_i | (advance & !load_use)`.
- Register state, evaluated at each edge in this priority:
  - `flush_i`: `ex_valid_o` <= 0.
  - `advance & load_use`: `ex_valid_o` <= 0 (bubble); ID is held.
  - `advance`: `ex_valid_o` <= `id_valid_i`; payload loaded when `id_valid_i`.
  - Otherwise: hold every output.
- Payload registers load only on accept, so they never change while `ex_valid_o & !ex_ready_i`.

## Timing
- Reset: every output register is 0, including `ex_valid_o`. `id_ready_o` = 1 after reset.
- Latency: 1 cycle from ID accept to `op*_o` valid.
- Load-use costs exactly one bubble cycle. On the next cycle the load is in MEM and its data is forwarded from `mem_data_i`.
- Flush together with `id_valid_i`: the incoming instruction is dropped and `ex_valid_o` = 0 next cycle.
- Flush during a downstream stall: the held instruction is discarded regardless of `ex_ready_i`.
- Reset asserted mid-stall: all state clears immediately, asynchronously.
- Arithmetic: none. The block only selects operands, so no width growth occurs.

## Configuration
- `PSRV_FWD_EN` defined: forwarding as described above.
- `PSRV_FWD_EN` undefined:
  - No bypass paths; operands come only from `rsN_data_i`, PC or imm.
  - Any read source matching an EX, MEM or WB writer with `rd != 0` behaves like `load_use`: one bubble per cycle until no match remains.
  - The register file writes before it reads within a cycle.

## Structure
- Shared package `psrv_pkg`:
  - `XLEN`.
  - ALU opcode constants: ADD 0, SLL 1, SLT 2, SLTU 3, XOR 4, SRL 5, OR 6, AND 7, SRA 8, SUB 9.
  - `OP1_RS1`/`OP1_PC` and `OP2_RS2`/`OP2_IMM` select constants.
- One sub-module, `id_ex_hazard_unit`: combinational. Produces `fwd_rs1`, `fwd_rs2` and `load_use`.

## Test plan
- Reset, then ADD with x1 = 5, imm = 7, `op2_sel_i = 1` -> next cycle `ex_valid_o = 1`, `op1_o = 5`, `op2_o = 7`, `aluop_o = 0`.
- Back-to-back dependency: EX holds `addi x3` with `ex_result_i = 0x10`; ID issues `sub x4, x3, x2` (x2 = 4) with stale `rs1_data_i = 0` -> `op1_o = 0x10`, `op2_o = 4`. MEM and WB also write x3 = 0x99 -> EX still wins.
- Load-use: EX holds `lw x5`, ID issues `add x6, x5, x0`:
  - Cycle 1: `id_ready_o = 0`, `ex_valid_o` becomes 0.
  - Cycle 2: `mem_data_i = 0xABCD` with `mem_addr_i = 5` -> `op1_o = 0xABCD`.
- Downstream stall: `ex_ready_i = 0` for 3 cycles with a valid ID instruction pending -> outputs stable, `id_ready_o = 0`; accepted on the cycle `ex_ready_i` rises.
- Flush during stall and with `id_valid_i = 1` -> `ex_valid_o = 0` next cycle, `id_ready_o = 1`, nothing captured.
- x0 hazard: EX writes `rd = 0` with `ex_result_i = 0xFFFF`, ID reads x0 -> `op1_o = 0`, no bubble. With `PSRV_FWD_EN` undefined, the dependency in scenario 2 inserts bubbles until x3 has left WB.
